// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-RAM port.
// Accepts one RV32I load/store at a time. It drives the RAM write-enable,
// address and data, and returns byte/half/word load results with sign or
// zero extension. Every output is registered.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// H/W requests complete at once with error=1 and touch no memory. When it is
// not defined, error is tied low and misaligned requests go to the RAM as-is.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              error,
    output logic [31:0]       load_data,
    output logic [2:0]        mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} size_t;

    // Access size from funct3. Encodings that are unsupported for the
    // direction (011, 11x, and BU/HU on stores) fall back to a word access.
    function automatic size_t decode_size(input logic store, input logic [2:0] funct3);
        case (funct3)
            3'b000:  return SIZE_B;
            3'b001:  return SIZE_H;
            3'b100:  return store ? SIZE_W : SIZE_B;
            3'b101:  return store ? SIZE_W : SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    // The RAM has already right-shifted the word by addr[1:0], so the
    // selected bytes always sit at the bottom of raw.
    function automatic logic [31:0] extend_load(input size_t size, input logic zero_ext,
                                                input logic [31:0] raw);
        case (size)
            SIZE_B:  return zero_ext ? {24'b0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
            SIZE_H:  return zero_ext ? {16'b0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Write-enable encoding expected by the RAM: bit0 word, bit1 half, bit2 byte.
    function automatic logic [2:0] store_enable(input size_t size);
        case (size)
            SIZE_B:  return 3'b100;
            SIZE_H:  return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    state_t            state, state_next;
    logic              is_store, is_store_next;
    size_t             size_q, size_next;
    logic              zero_ext, zero_ext_next;
    logic              req_ready_next;
    logic              done_next;
    logic [31:0]       load_data_next;
    logic [2:0]        write_enable_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [31:0]       mem_data_in_next;
    size_t             req_size;
    logic              req_zero_ext;

    assign req_size     = decode_size(req_store, req_funct3);
    assign req_zero_ext = !req_store && (req_funct3 == 3'b100 || req_funct3 == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
    logic error_q, error_next;
    logic req_misaligned;

    assign req_misaligned = (req_size == SIZE_H && req_addr[0]) ||
                            (req_size == SIZE_W && req_addr[1:0] != 2'b00);
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Next-state and next-output logic for the request sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next        = state;
        is_store_next     = is_store;
        size_next         = size_q;
        zero_ext_next     = zero_ext;
        done_next         = 1'b0;
        load_data_next    = load_data;
        write_enable_next = 3'b000;
        mem_addr_next     = mem_addr;
        mem_data_in_next  = mem_data_in;
`ifdef LSU_MISALIGN_TRAP_EN
        error_next        = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (req_valid) begin
                    is_store_next    = req_store;
                    size_next        = req_size;
                    zero_ext_next    = req_zero_ext;
                    mem_addr_next    = req_addr;
                    // Store data goes out unmodified; the RAM picks the low bytes.
                    mem_data_in_next = req_wdata;
                    state_next       = ACCESS;
                    if (req_store) begin
                        write_enable_next = store_enable(req_size);
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_misaligned) begin
                        state_next        = DONE;
                        write_enable_next = 3'b000;
                        done_next         = 1'b1;
                        error_next        = 1'b1;
                    end
`endif
                end
            end
            ACCESS: begin
                // The write strobe lasts only this cycle; the default clears it.
                if (is_store) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                load_data_next = extend_load(size_q, zero_ext, mem_data_out);
                state_next     = DONE;
                done_next      = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        req_ready_next = (state_next == IDLE);
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before the edge.
        if (reset) begin
            state            <= IDLE;
            is_store         <= 1'b0;
            size_q           <= SIZE_W;
            zero_ext         <= 1'b0;
            req_ready        <= 1'b1;
            done             <= 1'b0;
            load_data        <= 32'h0;
            mem_write_enable <= 3'b000;
            mem_addr         <= '0;
            mem_data_in      <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            error_q          <= 1'b0;
`endif
        end else begin
            state            <= state_next;
            is_store         <= is_store_next;
            size_q           <= size_next;
            zero_ext         <= zero_ext_next;
            req_ready        <= req_ready_next;
            done             <= done_next;
            load_data        <= load_data_next;
            mem_write_enable <= write_enable_next;
            mem_addr         <= mem_addr_next;
            mem_data_in      <= mem_data_in_next;
`ifdef LSU_MISALIGN_TRAP_EN
            error_q          <= error_next;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte-level
// RAM model. Expected results come from a shadow memory that is updated when
// stimulus is issued. They are checked when the DUT pulses done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic [2:0]  mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .error(error), .load_data(load_data),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 256 bytes, registered read already shifted by addr[1:0],
    // byte/half/word writes, GPIO byte at 0xA0.
    logic [7:0] ram [256];
    logic [7:0] gpio;
    logic       ram_init;
    logic [7:0] ra0, ra1, ra2, ra3;
    assign ra0 = mem_addr[7:0];
    assign ra1 = ra0 + 8'd1;
    assign ra2 = ra0 + 8'd2;
    assign ra3 = ra0 + 8'd3;

    // RAM write and registered read port.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
            gpio <= 8'h00;
        end else if (mem_write_enable[0]) begin
            ram[ra0] <= mem_data_in[7:0];
            ram[ra1] <= mem_data_in[15:8];
            ram[ra2] <= mem_data_in[23:16];
            ram[ra3] <= mem_data_in[31:24];
        end else if (mem_write_enable[1]) begin
            ram[ra0] <= mem_data_in[7:0];
            ram[ra1] <= mem_data_in[15:8];
        end else if (mem_write_enable[2]) begin
            ram[ra0] <= mem_data_in[7:0];
            if (mem_addr == 32'hA0) gpio <= mem_data_in[7:0];
        end
        mem_data_out <= {ram[ra3], ram[ra2], ram[ra1], ram[ra0]};
    end

    // Shadow memory and reference model.
    logic [7:0]  sh [256];
    logic [31:0] last_load = 32'h0;

    function automatic int acc_size(input logic st, input logic [2:0] f3);
        if (f3 == 3'b000) return 1;
        if (f3 == 3'b001) return 2;
        if (!st && f3 == 3'b100) return 1;
        if (!st && f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [7:0]  a;
        logic [31:0] w;
        a = addr[7:0];
        w = {sh[a + 8'd3], sh[a + 8'd2], sh[a + 8'd1], sh[a]};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic sh_store(input int n, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < n; i++) sh[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        logic [2:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t sb[$];

    // Monitor: tracks write strobes and checks each done against the scoreboard.
    exp_t        m_e;
    int          we_cnt = 0;
    int          we_cyc = 0;
    logic [2:0]  we_seen;
    logic [31:0] din_seen;

    always @(negedge clk) begin
        if (reset) begin
            we_cnt = 0;
        end else begin
            if (mem_write_enable !== 3'b000) begin
                we_cnt++;
                we_cyc   = cyc;
                we_seen  = mem_write_enable;
                din_seen = mem_data_in;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    m_e = sb.pop_front();
                    vectors++;
                    if (load_data !== m_e.data) begin
                        miscompares++;
                        $display("FAIL load_data addr=%h got %h expected %h", m_e.addr, load_data, m_e.data);
                    end
                    vectors++;
                    if (error !== m_e.err) begin
                        miscompares++;
                        $display("FAIL error addr=%h got %b expected %b", m_e.addr, error, m_e.err);
                    end
                    vectors++;
                    if (cyc - m_e.acc != m_e.lat) begin
                        miscompares++;
                        $display("FAIL done_latency addr=%h got %0d expected %0d", m_e.addr, cyc - m_e.acc, m_e.lat);
                    end
                    vectors++;
                    if (mem_addr !== m_e.addr) begin
                        miscompares++;
                        $display("FAIL mem_addr_hold got %h expected %h", mem_addr, m_e.addr);
                    end
                    vectors++;
                    if (we_cnt != ((m_e.we != 3'b000) ? 1 : 0)) begin
                        miscompares++;
                        $display("FAIL we_cycles addr=%h got %0d expected %0d", m_e.addr, we_cnt, (m_e.we != 3'b000) ? 1 : 0);
                    end
                    if (m_e.we != 3'b000 && we_cnt > 0) begin
                        vectors++;
                        if (we_seen !== m_e.we || din_seen !== m_e.wdata || we_cyc - m_e.acc != 1) begin
                            miscompares++;
                            $display("FAIL store_strobe got we=%b din=%h at +%0d expected we=%b din=%h at +1",
                                     we_seen, din_seen, we_cyc - m_e.acc, m_e.we, m_e.wdata);
                        end
                    end
                    we_cnt = 0;
                end
            end
        end
    end

    // Bounded wait, entered and left on a negedge, until req_ready is high.
    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout req_ready=%b expected 1", req_ready);
        end
    endtask

    // Bounded wait until every scoreboard entry has been retired.
    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Build the expected result for one request and update the shadow memory.
    task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        exp_t e;
        int   n;
        logic mis;
        n   = acc_size(st, f3);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
        e.addr  = addr;
        e.wdata = wdata;
        e.acc   = cyc;
        if (mis) begin
            e.err = 1'b1; e.lat = 1; e.we = 3'b000; e.data = last_load;
        end else if (st) begin
            e.err = 1'b0; e.lat = 2; e.data = last_load;
            e.we  = (n == 1) ? 3'b100 : (n == 2) ? 3'b010 : 3'b001;
            sh_store(n, addr, wdata);
        end else begin
            e.err = 1'b0; e.lat = 3; e.we = 3'b000;
            e.data = model_load(f3, addr);
            last_load = e.data;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    endtask

    // Issue one request and wait for it to complete.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        wait_ready();
        predict(st, f3, addr, wdata);
        drive(st, f3, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", done); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b expected 0", error); end
        vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL reset_load_data got %h expected 0", load_data); end
        vectors++; if (mem_write_enable !== 3'b000) begin miscompares++; $display("FAIL reset_we got %b expected 000", mem_write_enable); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h expected 0", mem_addr); end
        vectors++; if (mem_data_in !== 32'h0) begin miscompares++; $display("FAIL reset_mem_data_in got %h expected 0", mem_data_in); end
        ram_init = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h40, 32'h0);
    endtask

    task automatic test_subword();
        issue(1'b0, 3'b000, 32'h43, 32'h0);
        issue(1'b0, 3'b100, 32'h43, 32'h0);
        issue(1'b0, 3'b001, 32'h42, 32'h0);
        issue(1'b0, 3'b101, 32'h40, 32'h0);
        issue(1'b1, 3'b001, 32'h44, 32'h12348001);
        issue(1'b0, 3'b001, 32'h44, 32'h0);
        issue(1'b0, 3'b101, 32'h44, 32'h0);
        issue(1'b1, 3'b000, 32'h47, 32'hFFFFFF7F);
        issue(1'b0, 3'b000, 32'h47, 32'h0);
    endtask

    task automatic test_gpio();
        issue(1'b1, 3'b000, 32'hA0, 32'h000000A5);
        vectors++;
        if (gpio !== 8'hA5) begin
            miscompares++;
            $display("FAIL gpio got %h expected a5", gpio);
        end
    endtask

    task automatic test_funct3_fallback();
        issue(1'b1, 3'b100, 32'h48, 32'hCAFEF00D);
        issue(1'b0, 3'b011, 32'h48, 32'h0);
        issue(1'b0, 3'b111, 32'h40, 32'h0);
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (req_ready !== ((i % 4) == 0)) begin
                miscompares++;
                $display("FAIL b2b_ready cycle %0d got %b expected %b", i, req_ready, (i % 4) == 0);
            end
            if (req_ready === 1'b1) accepts++;
            if ((i % 4) == 0) predict(1'b0, 3'b010, 32'h44, 32'h0);
            drive(1'b0, 3'b010, 32'h44, 32'h0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        vectors++;
        if (accepts != 3) begin
            miscompares++;
            $display("FAIL b2b_accepts got %0d expected 3", accepts);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        // Load interrupted in CAPTURE: everything clears, no done follows.
        wait_ready();
        drive(1'b0, 3'b010, 32'h40, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done got %b expected 0", done); end
        vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL midreset_load_data got %h expected 0", load_data); end
        vectors++; if (mem_write_enable !== 3'b000) begin miscompares++; $display("FAIL midreset_we got %b expected 000", mem_write_enable); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready got %b expected 1", req_ready); end
        last_load = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_stray_done cycle %0d got %b expected 0", i, done);
            end
        end
        // Store interrupted in ACCESS: the write still lands in the RAM.
        wait_ready();
        sh_store(4, 32'h50, 32'h11223344);
        drive(1'b1, 3'b010, 32'h50, 32'h11223344);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (mem_write_enable !== 3'b000) begin miscompares++; $display("FAIL access_reset_we got %b expected 000", mem_write_enable); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL access_reset_done got %b expected 0", done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h50, 32'h0);
    endtask

    task automatic test_misalign();
        issue(1'b0, 3'b010, 32'h41, 32'h0);
        issue(1'b0, 3'b001, 32'h43, 32'h0);
        issue(1'b0, 3'b000, 32'h41, 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        ram_init   = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) sh[i] = 8'(i * 7 + 3);

        test_reset();
        test_word();
        test_subword();
        test_gpio();
        test_funct3_fallback();
        test_back_to_back();
        test_reset_mid();
        test_misalign();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
